// File: rtl/insn_fetch_mem_if.sv
// insn_fetch_mem_if: fetch, stall, loader and result signals of the instruction memory
//   master: pipeline/loader side (drives fetch_req, fetch_addr, stall, load_*)
//   slave : memory side (drives insn_out, insn_valid, insn_fault, insn_addr_out)
interface insn_fetch_mem_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 32
);
  logic                     fetch_req;
  logic [AW-1:0]            fetch_addr;
  logic                     stall;
  logic                     load_we;
  logic [$clog2(DEPTH)-1:0] load_idx;
  logic [XLEN-1:0]          load_data;
  logic [XLEN-1:0]          insn_out;
  logic                     insn_valid;
  logic                     insn_fault;
  logic [AW-1:0]            insn_addr_out;
  modport master (
    output fetch_req, fetch_addr, stall, load_we, load_idx, load_data,
    input  insn_out, insn_valid, insn_fault, insn_addr_out
  );
  modport slave (
    input  fetch_req, fetch_addr, stall, load_we, load_idx, load_data,
    output insn_out, insn_valid, insn_fault, insn_addr_out
  );
endinterface

// File: rtl/insn_fetch_mem.sv
// insn_fetch_mem: loader-written instruction memory with 1- or 2-cycle fetch, fault detection and stall
//   clk, rst : clock and asynchronous active-high reset
//   bus      : insn_fetch_mem_if.slave (fetch request/address, stall, loader port, fetched result)
module insn_fetch_mem #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 1024,
  parameter int              AW       = 32,
  parameter int              OUT_REG  = 0,
  parameter logic [XLEN-1:0] NOP_WORD = 32'h00000013
) (
  input logic clk,
  input logic rst,
  insn_fetch_mem_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [IW-1:0]   idx;
  logic            flt;
  logic            s1_valid_q, s1_valid_d, s1_fault_q, s1_fault_d;
  logic            s2_valid_q, s2_valid_d, s2_fault_q, s2_fault_d;
  logic [AW-1:0]   s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [XLEN-1:0] s1_word_q, s1_word_d, s2_word_q, s2_word_d;
  assign idx = bus.fetch_addr[2 +: IW];
  // DEPTH is a power of two, so any set bit above the index field means out of range
  assign flt = (|bus.fetch_addr[1:0]) || (|(bus.fetch_addr >> (2 + IW)));
  always_ff @(posedge clk)
    if (bus.load_we && !rst) mem[bus.load_idx] <= bus.load_data;
  always_comb begin
    s1_valid_d = bus.stall ? s1_valid_q : bus.fetch_req;
    s1_fault_d = bus.stall ? s1_fault_q : bus.fetch_req && flt;
    s1_addr_d  = bus.stall ? s1_addr_q  : bus.fetch_addr;
    s1_word_d  = bus.stall ? s1_word_q  : (!bus.fetch_req || flt) ? NOP_WORD : mem[idx];
    s2_valid_d = bus.stall ? s2_valid_q : s1_valid_q;
    s2_fault_d = bus.stall ? s2_fault_q : s1_fault_q;
    s2_addr_d  = bus.stall ? s2_addr_q  : s1_addr_q;
    s2_word_d  = bus.stall ? s2_word_q  : s1_word_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fault_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_word_q  <= NOP_WORD;
      s2_valid_q <= 1'b0;
      s2_fault_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_word_q  <= NOP_WORD;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fault_q <= s1_fault_d;
      s1_addr_q  <= s1_addr_d;
      s1_word_q  <= s1_word_d;
      s2_valid_q <= s2_valid_d;
      s2_fault_q <= s2_fault_d;
      s2_addr_q  <= s2_addr_d;
      s2_word_q  <= s2_word_d;
    end
  assign bus.insn_valid    = (OUT_REG != 0) ? s2_valid_q : s1_valid_q;
  assign bus.insn_fault    = (OUT_REG != 0) ? s2_fault_q : s1_fault_q;
  assign bus.insn_addr_out = (OUT_REG != 0) ? s2_addr_q  : s1_addr_q;
  assign bus.insn_out      = (OUT_REG != 0) ? s2_word_q  : s1_word_q;
endmodule

// File: tb/tb_insn_fetch_mem.sv
// tb_insn_fetch_mem: directed checks of insn_fetch_mem with OUT_REG=0 (d0) and OUT_REG=1 (d1)
module tb_insn_fetch_mem;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  insn_fetch_mem_if #(.XLEN(32), .DEPTH(1024), .AW(32)) if0 ();
  insn_fetch_mem_if #(.XLEN(32), .DEPTH(1024), .AW(32)) if1 ();
  insn_fetch_mem #(.XLEN(32), .DEPTH(1024), .AW(32), .OUT_REG(0), .NOP_WORD(NOP)) d0 (.clk(clk), .rst(rst), .bus(if0));
  insn_fetch_mem #(.XLEN(32), .DEPTH(1024), .AW(32), .OUT_REG(1), .NOP_WORD(NOP)) d1 (.clk(clk), .rst(rst), .bus(if1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic req, input logic [31:0] a, input logic st,
                     input logic we, input logic [9:0] idx, input logic [31:0] d);
    if0.fetch_req = req; if0.fetch_addr = a; if0.stall = st;
    if0.load_we = we; if0.load_idx = idx; if0.load_data = d;
    if1.fetch_req = req; if1.fetch_addr = a; if1.stall = st;
    if1.load_we = we; if1.load_idx = idx; if1.load_data = d;
  endtask
  task automatic cyc(input logic req, input logic [31:0] a, input logic st,
                     input logic we, input logic [9:0] idx, input logic [31:0] d);
    drv(req, a, st, we, idx, d);
    @(posedge clk);
    #1;
  endtask
  task automatic out0(input string tag, input logic v, input logic f, input logic [31:0] a, input logic [31:0] w);
    chk({tag, ".d0.valid"}, {31'd0, if0.insn_valid}, {31'd0, v});
    chk({tag, ".d0.fault"}, {31'd0, if0.insn_fault}, {31'd0, f});
    chk({tag, ".d0.addr"}, if0.insn_addr_out, a);
    chk({tag, ".d0.insn"}, if0.insn_out, w);
  endtask
  task automatic out1(input string tag, input logic v, input logic f, input logic [31:0] a, input logic [31:0] w);
    chk({tag, ".d1.valid"}, {31'd0, if1.insn_valid}, {31'd0, v});
    chk({tag, ".d1.fault"}, {31'd0, if1.insn_fault}, {31'd0, f});
    chk({tag, ".d1.addr"}, if1.insn_addr_out, a);
    chk({tag, ".d1.insn"}, if1.insn_out, w);
  endtask
  task automatic v1(input string tag, input logic v);
    chk({tag, ".d1.valid"}, {31'd0, if1.insn_valid}, {31'd0, v});
  endtask
  initial begin
    drv(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    #1 rst = 1'b1;
    #2;
    out0("reset", 1'b0, 1'b0, 32'h0, NOP);
    out1("reset", 1'b0, 1'b0, 32'h0, NOP);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 10'd0, 32'h11111111);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 10'd1, 32'h22222222);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 10'd2, 32'h33333333);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 10'd3, 32'h44444444);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 10'd5, 32'h55555555);
    out0("bubble", 1'b0, 1'b0, 32'h0, NOP);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("b2b0", 1'b1, 1'b0, 32'h0, 32'h11111111);
    v1("b2b0", 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("b2b4", 1'b1, 1'b0, 32'h4, 32'h22222222);
    out1("b2b4", 1'b1, 1'b0, 32'h0, 32'h11111111);
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("b2b8", 1'b1, 1'b0, 32'h8, 32'h33333333);
    out1("b2b8", 1'b1, 1'b0, 32'h4, 32'h22222222);
    cyc(1'b1, 32'hC, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("b2bC", 1'b1, 1'b0, 32'hC, 32'h44444444);
    out1("b2bC", 1'b1, 1'b0, 32'h8, 32'h33333333);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    chk("b2b_end.d0.valid", {31'd0, if0.insn_valid}, 32'd0);
    out1("b2b_end", 1'b1, 1'b0, 32'hC, 32'h44444444);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    v1("b2b_drain", 1'b0);
    cyc(1'b1, 32'h6, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("misalign", 1'b1, 1'b1, 32'h6, NOP);
    cyc(1'b1, 32'h1000, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("range", 1'b1, 1'b1, 32'h1000, NOP);
    out1("misalign", 1'b1, 1'b1, 32'h6, NOP);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    out1("range", 1'b1, 1'b1, 32'h1000, NOP);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    v1("stall_acc", 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h4, 1'b1, 1'b0, 10'd0, 32'h0);
      out0("stall_hold", 1'b1, 1'b0, 32'h0, 32'h11111111);
      v1("stall_hold", 1'b0);
    end
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("release", 1'b1, 1'b0, 32'h4, 32'h22222222);
    out1("release", 1'b1, 1'b0, 32'h0, 32'h11111111);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    out1("release2", 1'b1, 1'b0, 32'h4, 32'h22222222);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    v1("release_once", 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b1, 10'd2, 32'hDEADBEEF);
    out0("rd_old", 1'b1, 1'b0, 32'h8, 32'h33333333);
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("rd_new", 1'b1, 1'b0, 32'h8, 32'hDEADBEEF);
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 10'd0, 32'h0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 10'd0, 32'h0);
    out1("pre_rst", 1'b1, 1'b0, 32'h4, 32'h22222222);
    drv(1'b1, 32'hC, 1'b0, 1'b1, 10'd5, 32'hBAD0BAD0);
    rst = 1'b1;
    #1;
    out0("mid_rst", 1'b0, 1'b0, 32'h0, NOP);
    out1("mid_rst", 1'b0, 1'b0, 32'h0, NOP);
    @(posedge clk);
    #1;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    rst = 1'b0;
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("first_fetch", 1'b1, 1'b0, 32'h4, 32'h22222222);
    v1("no_stale", 1'b0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 10'd0, 32'h0);
    out0("rst_keep", 1'b1, 1'b0, 32'h14, 32'h55555555);
    out1("first_fetch", 1'b1, 1'b0, 32'h4, 32'h22222222);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    out1("rst_keep", 1'b1, 1'b0, 32'h14, 32'h55555555);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
